// File: rtl/id_exe_stage_reg_pkg.sv
// rtl/id_exe_stage_reg_pkg.sv - shared core types for the ID/EXE pipeline register
package id_exe_stage_reg_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CMD_W  = 4;

   typedef enum logic [CMD_W-1:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001
   } exe_cmd_e;

   typedef struct packed {
      logic mem_r_en;
      logic mem_w_en;
      logic wb_en;
      logic b;
      logic s;
   } ctrl_t;

   // All side-effecting control bits cleared: an instruction carrying this is inert.
   localparam ctrl_t BUBBLE_CTRL = '0;

   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      return valid ? c : BUBBLE_CTRL;
   endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// rtl/id_exe_stage_reg_if.sv - ID-side inputs and EXE-side registered copies
interface id_exe_if #(
   parameter int DATA_W = id_exe_stage_reg_pkg::DATA_W,
   parameter int REG_AW = id_exe_stage_reg_pkg::REG_AW,
   parameter int CMD_W  = id_exe_stage_reg_pkg::CMD_W
);
   logic              id_valid;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_val_rn;
   logic [DATA_W-1:0] id_val_rm;
   logic [11:0]       id_shift_op;
   logic              id_imm;
   logic [23:0]       id_simm24;
   logic [CMD_W-1:0]  id_exe_cmd;
   logic              id_mem_r_en;
   logic              id_mem_w_en;
   logic              id_wb_en;
   logic              id_b;
   logic              id_s;
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic [REG_AW-1:0] id_dest;
   logic              id_two_regs;
   logic              id_status_c;

   logic              exe_valid;
   logic [DATA_W-1:0] exe_pc;
   logic [DATA_W-1:0] exe_val_rn;
   logic [DATA_W-1:0] exe_val_rm;
   logic [11:0]       exe_shift_op;
   logic              exe_imm;
   logic [23:0]       exe_simm24;
   logic [CMD_W-1:0]  exe_exe_cmd;
   logic              exe_mem_r_en;
   logic              exe_mem_w_en;
   logic              exe_wb_en;
   logic              exe_b;
   logic              exe_s;
   logic [REG_AW-1:0] exe_src1;
   logic [REG_AW-1:0] exe_src2;
   logic [REG_AW-1:0] exe_dest;
   logic              exe_two_regs;
   logic              exe_status_c;

   // master: the ID stage side; slave: the pipeline register itself
   modport master (
      output id_valid, id_pc, id_val_rn, id_val_rm, id_shift_op, id_imm, id_simm24,
             id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s,
             id_src1, id_src2, id_dest, id_two_regs, id_status_c,
      input  exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_shift_op, exe_imm, exe_simm24,
             exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s,
             exe_src1, exe_src2, exe_dest, exe_two_regs, exe_status_c
   );

   modport slave (
      input  id_valid, id_pc, id_val_rn, id_val_rm, id_shift_op, id_imm, id_simm24,
             id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s,
             id_src1, id_src2, id_dest, id_two_regs, id_status_c,
      output exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_shift_op, exe_imm, exe_simm24,
             exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s,
             exe_src1, exe_src2, exe_dest, exe_two_regs, exe_status_c
   );
endinterface

// File: rtl/id_exe_stage_reg_pipe_field_reg.sv
// rtl/id_exe_stage_reg_pipe_field_reg.sv - field-group register with hold and clear
module pipe_field_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // hold outranks clear so a frozen stage drops a concurrent bubble request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (!hold) begin
         q <= clear ? '0 : d;
      end
   end

endmodule

// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - ID/EXE pipeline register with freeze, flush, bubble and bubble counter
module id_exe_stage_reg #(
   parameter int DATA_W = id_exe_stage_reg_pkg::DATA_W,
   parameter int REG_AW = id_exe_stage_reg_pkg::REG_AW,
   parameter int CMD_W  = id_exe_stage_reg_pkg::CMD_W,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             bubble,
   input  logic             cnt_clr,
   id_exe_if.slave          bus,
   output logic [CNT_W-1:0] bubble_cnt
);
   import id_exe_stage_reg_pkg::ctrl_t;
   import id_exe_stage_reg_pkg::gate_ctrl;

   localparam int CTRL_GW = 1 + $bits(ctrl_t) + CMD_W + 2;
   localparam int OPND_GW = 3 * DATA_W + 12 + 24;
   localparam int IDX_GW  = 3 * REG_AW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic               insert_nop;
   ctrl_t              id_ctrl;
   ctrl_t              exe_ctrl;
   logic [CTRL_GW-1:0] ctrl_d, ctrl_q;
   logic [OPND_GW-1:0] opnd_d, opnd_q;
   logic [IDX_GW-1:0]  idx_d,  idx_q;

   assign insert_nop = flush | bubble;

   assign id_ctrl = '{mem_r_en: bus.id_mem_r_en,
                      mem_w_en: bus.id_mem_w_en,
                      wb_en:    bus.id_wb_en,
                      b:        bus.id_b,
                      s:        bus.id_s};

   // Invalid ID slots still carry their data fields; only side effects are stripped.
   assign ctrl_d = {bus.id_valid, gate_ctrl(id_ctrl, bus.id_valid),
                    bus.id_exe_cmd, bus.id_imm, bus.id_status_c};
   assign opnd_d = {bus.id_pc, bus.id_val_rn, bus.id_val_rm,
                    bus.id_shift_op, bus.id_simm24};
   assign idx_d  = {bus.id_src1, bus.id_src2, bus.id_dest, bus.id_two_regs};

   pipe_field_reg #(.W(CTRL_GW)) u_ctrl_reg (
      .clk   (clk),
      .rst   (rst),
      .hold  (freeze),
      .clear (insert_nop),
      .d     (ctrl_d),
      .q     (ctrl_q)
   );

   pipe_field_reg #(.W(OPND_GW)) u_opnd_reg (
      .clk   (clk),
      .rst   (rst),
      .hold  (freeze),
      .clear (insert_nop),
      .d     (opnd_d),
      .q     (opnd_q)
   );

   // A cleared dest with wb_en=0 keeps the forwarding unit from matching a bubble.
   pipe_field_reg #(.W(IDX_GW)) u_idx_reg (
      .clk   (clk),
      .rst   (rst),
      .hold  (freeze),
      .clear (insert_nop),
      .d     (idx_d),
      .q     (idx_q)
   );

   assign {bus.exe_valid, exe_ctrl, bus.exe_exe_cmd, bus.exe_imm, bus.exe_status_c} = ctrl_q;
   assign bus.exe_mem_r_en = exe_ctrl.mem_r_en;
   assign bus.exe_mem_w_en = exe_ctrl.mem_w_en;
   assign bus.exe_wb_en    = exe_ctrl.wb_en;
   assign bus.exe_b        = exe_ctrl.b;
   assign bus.exe_s        = exe_ctrl.s;
   assign {bus.exe_pc, bus.exe_val_rn, bus.exe_val_rm,
           bus.exe_shift_op, bus.exe_simm24} = opnd_q;
   assign {bus.exe_src1, bus.exe_src2, bus.exe_dest, bus.exe_two_regs} = idx_q;

   // Saturating count of inserted bubbles; clear wins over a same-edge increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (!freeze) begin
         if (cnt_clr) begin
            bubble_cnt <= '0;
         end else if (insert_nop && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb/tb_id_exe_stage_reg.sv - self-checking bench for id_exe_stage_reg
module tb_id_exe_stage_reg;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] val_rn;
      logic [31:0] val_rm;
      logic [11:0] shift_op;
      logic        imm;
      logic [23:0] simm24;
      logic [3:0]  exe_cmd;
      logic        mem_r_en;
      logic        mem_w_en;
      logic        wb_en;
      logic        b;
      logic        s;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [4:0]  dest;
      logic        two_regs;
      logic        status_c;
   } fld_t;

   logic clk = 1'b0;
   logic rst, freeze, flush, bubble, cnt_clr;
   logic [CNT_W-1:0] bubble_cnt;
   fld_t stim, act, exp_f;
   int   exp_cnt;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   id_exe_if bus ();

   id_exe_stage_reg #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .flush      (flush),
      .bubble     (bubble),
      .cnt_clr    (cnt_clr),
      .bus        (bus),
      .bubble_cnt (bubble_cnt)
   );

   assign bus.id_valid    = stim.valid;
   assign bus.id_pc       = stim.pc;
   assign bus.id_val_rn   = stim.val_rn;
   assign bus.id_val_rm   = stim.val_rm;
   assign bus.id_shift_op = stim.shift_op;
   assign bus.id_imm      = stim.imm;
   assign bus.id_simm24   = stim.simm24;
   assign bus.id_exe_cmd  = stim.exe_cmd;
   assign bus.id_mem_r_en = stim.mem_r_en;
   assign bus.id_mem_w_en = stim.mem_w_en;
   assign bus.id_wb_en    = stim.wb_en;
   assign bus.id_b        = stim.b;
   assign bus.id_s        = stim.s;
   assign bus.id_src1     = stim.src1;
   assign bus.id_src2     = stim.src2;
   assign bus.id_dest     = stim.dest;
   assign bus.id_two_regs = stim.two_regs;
   assign bus.id_status_c = stim.status_c;

   assign act = '{valid: bus.exe_valid, pc: bus.exe_pc, val_rn: bus.exe_val_rn,
                  val_rm: bus.exe_val_rm, shift_op: bus.exe_shift_op, imm: bus.exe_imm,
                  simm24: bus.exe_simm24, exe_cmd: bus.exe_exe_cmd,
                  mem_r_en: bus.exe_mem_r_en, mem_w_en: bus.exe_mem_w_en,
                  wb_en: bus.exe_wb_en, b: bus.exe_b, s: bus.exe_s,
                  src1: bus.exe_src1, src2: bus.exe_src2, dest: bus.exe_dest,
                  two_regs: bus.exe_two_regs, status_c: bus.exe_status_c};

   task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference: what EXE should hold after an edge, given what ID and hazard lines showed.
   task automatic model_edge();
      if (rst) begin
         exp_f   = '0;
         exp_cnt = 0;
      end else if (!freeze) begin
         if (flush || bubble) begin
            exp_f = '0;
         end else begin
            exp_f = stim;
            if (!stim.valid) begin
               exp_f.mem_r_en = 1'b0;
               exp_f.mem_w_en = 1'b0;
               exp_f.wb_en    = 1'b0;
               exp_f.b        = 1'b0;
               exp_f.s        = 1'b0;
            end
         end
         if (cnt_clr)
            exp_cnt = 0;
         else if ((flush || bubble) && exp_cnt < (1 << CNT_W) - 1)
            exp_cnt = exp_cnt + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk_eq("exe_fields", act, exp_f);
      chk_eq("bubble_cnt", bubble_cnt, exp_cnt);
   endtask

   task automatic rand_stim();
      stim = fld_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0; cnt_clr = 1'b0;
      stim = '0; exp_f = '0; exp_cnt = 0;
      repeat (2) @(negedge clk);
      chk_eq("reset_fields", act, '0);
      chk_eq("reset_cnt", bubble_cnt, 0);

      rst = 1'b0;
      stim = '0; stim.pc = 32'h104; stim.dest = 5'd3; stim.wb_en = 1'b1; stim.valid = 1'b1;
      tick();
      chk_eq("load_pc", bus.exe_pc, 32'h104);
      chk_eq("load_dest", bus.exe_dest, 3);
      chk_eq("load_wb_en", bus.exe_wb_en, 1);
      chk_eq("load_valid", bus.exe_valid, 1);

      freeze = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_stim();
         tick();
      end
      chk_eq("frozen_pc", bus.exe_pc, 32'h104);
      chk_eq("frozen_cnt", bubble_cnt, 0);
      freeze = 1'b0;
      tick();
      chk_eq("flush_valid", bus.exe_valid, 0);
      chk_eq("flush_wb_en", bus.exe_wb_en, 0);
      chk_eq("flush_cnt", bubble_cnt, 1);

      flush = 1'b0; bubble = 1'b1;
      rand_stim(); stim.valid = 1'b1; stim.wb_en = 1'b1; stim.dest = 5'd7;
      tick();
      chk_eq("bubble_dest", bus.exe_dest, 0);
      chk_eq("bubble_wb_en", bus.exe_wb_en, 0);
      bubble = 1'b0;
      stim.src1 = 5'd5;
      tick();
      chk_eq("after_bubble_src1", bus.exe_src1, 5);

      rand_stim(); stim.valid = 1'b0; stim.mem_w_en = 1'b1; stim.val_rm = 32'hDEAD;
      tick();
      chk_eq("invalid_mem_w_en", bus.exe_mem_w_en, 0);
      chk_eq("invalid_val_rm", bus.exe_val_rm, 32'hDEAD);
      chk_eq("invalid_valid", bus.exe_valid, 0);

      stim = '0; stim.pc = 32'h100; stim.wb_en = 1'b1; stim.valid = 1'b1;
      tick();
      freeze = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      chk_eq("async_rst_fields", act, '0);
      chk_eq("async_rst_cnt", bubble_cnt, 0);
      tick();
      rst = 1'b0; freeze = 1'b0;
      tick();
      chk_eq("post_rst_pc", bus.exe_pc, 32'h100);

      bubble = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rand_stim();
         tick();
      end
      chk_eq("cnt_saturated", bubble_cnt, 15);
      cnt_clr = 1'b1;
      tick();
      chk_eq("cnt_clr_wins", bubble_cnt, 0);
      cnt_clr = 1'b0; bubble = 1'b0;

      for (int i = 0; i < 400; i++) begin
         rand_stim();
         freeze  = ($urandom_range(0, 4) == 0);
         flush   = ($urandom_range(0, 7) == 0);
         bubble  = ($urandom_range(0, 5) == 0);
         cnt_clr = ($urandom_range(0, 29) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
